// File: rtl/ase_pkg.sv
// Shared CCI-P C1 Tx types and helpers for the C1 Tx arbiter.
package ase_pkg;

  localparam int CCIP_DATA_WIDTH = 512;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef enum logic {
    C1ARB_IDLE  = 1'b0,
    C1ARB_BURST = 1'b1
  } t_c1arb_state;

  // Only line writes can span several cachelines; anything else is one beat.
  function automatic logic [2:0] c1arb_beats(t_ccip_c1_req req_type, t_ccip_clLen cl_len);
    logic multi;
    multi = (req_type == eREQ_WRLINE_I) || (req_type == eREQ_WRLINE_M) ||
            (req_type == eREQ_WRPUSH_I);
    if (!multi) return 3'd1;
    case (cl_len)
      eCL_LEN_2: return 3'd2;
      eCL_LEN_4: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker: first valid requester after rr_ptr, with wrap.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_c1tx_arbiter.sv
// Round-robin C1 Tx arbiter keeping multi-line write bursts atomic.
// Per-requester grant counters exist only when ASE_C1TX_ARB_STATS_EN is defined.
//   state       | meaning
//   C1ARB_IDLE  | no burst open, round-robin pick among valid requesters
//   C1ARB_BURST | locked to owner_q until beats_left_q reaches zero
module ccip_c1tx_arbiter
  import ase_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                                    clk,
  input  logic                                    SoftReset_n,
  input  logic                                    c1TxAlmFull,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  t_ccip_c1_ReqMemHdr [NUM_REQ-1:0]        req_hdr,
  input  logic [NUM_REQ-1:0][CCIP_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                      req_ack,
  output logic                                    c1_valid,
  output t_ccip_c1_ReqMemHdr                      c1_hdr,
  output logic [CCIP_DATA_WIDTH-1:0]              c1_data
`ifdef ASE_C1TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  t_c1arb_state         state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [1:0]           beats_left_q, beats_left_d;
  logic                 c1_valid_q;
  t_ccip_c1_ReqMemHdr   c1_hdr_q;
  logic [CCIP_DATA_WIDTH-1:0] c1_data_q;

  logic                 en;
  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_any;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     ack_idx;
  logic [2:0]           nbeats;

  assign en = !c1TxAlmFull;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_grant[i]) pick_idx = PTR_W'(i);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    req_ack      = '0;
    ack_idx      = owner_q;
    nbeats       = 3'd1;
    case (state_q)
      C1ARB_IDLE: begin
        if (en && pick_any) begin
          req_ack  = pick_grant;
          ack_idx  = pick_idx;
          rr_ptr_d = pick_idx;
          owner_d  = pick_idx;
          nbeats   = c1arb_beats(req_hdr[pick_idx].req_type, req_hdr[pick_idx].cl_len);
          if (nbeats != 3'd1) begin
            state_d      = C1ARB_BURST;
            beats_left_d = 2'(nbeats - 3'd1);
          end
        end
      end
      C1ARB_BURST: begin
        // Stalled bursts simply wait; nobody else may slip in between beats.
        if (en && req_valid[owner_q]) begin
          req_ack[owner_q] = 1'b1;
          beats_left_d     = beats_left_q - 2'd1;
          if (beats_left_q == 2'd1) state_d = C1ARB_IDLE;
        end
      end
      default: state_d = C1ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_q      <= C1ARB_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
      beats_left_q <= '0;
      c1_valid_q   <= 1'b0;
      c1_hdr_q     <= '0;
      c1_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
      c1_valid_q   <= |req_ack;
      if (|req_ack) begin
        c1_hdr_q  <= req_hdr[ack_idx];
        c1_data_q <= req_data[ack_idx];
      end
    end
  end

  assign c1_valid = c1_valid_q;
  assign c1_hdr   = c1_hdr_q;
  assign c1_data  = c1_data_q;

`ifdef ASE_C1TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q;

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ack[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// Directed bench for ccip_c1tx_arbiter with a cycle-level behavioural model.
// Counter checks are compiled in when ASE_C1TX_ARB_STATS_EN is defined.
module tb_ccip_c1tx_arbiter;
  import ase_pkg::*;

  localparam int N = 4;

  logic                              clk = 1'b0;
  logic                              SoftReset_n;
  logic                              c1TxAlmFull;
  logic [N-1:0]                      req_valid;
  t_ccip_c1_ReqMemHdr [N-1:0]        req_hdr;
  logic [N-1:0][CCIP_DATA_WIDTH-1:0] req_data;
  logic [N-1:0]                      req_ack;
  logic                              c1_valid;
  t_ccip_c1_ReqMemHdr                c1_hdr;
  logic [CCIP_DATA_WIDTH-1:0]        c1_data;
`ifdef ASE_C1TX_ARB_STATS_EN
  logic [N-1:0][31:0]                grant_cnt;
`endif

  ccip_c1tx_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .SoftReset_n (SoftReset_n),
    .c1TxAlmFull (c1TxAlmFull),
    .req_valid   (req_valid),
    .req_hdr     (req_hdr),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .c1_valid    (c1_valid),
    .c1_hdr      (c1_hdr),
    .c1_data     (c1_data)
`ifdef ASE_C1TX_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tag = 32'h100;
  int ack_log[$];

  task automatic chk(string name, logic [639:0] act, logic [639:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: last winner, open burst (owner, remaining beats), output register.
  int                          m_last;
  bit                          m_burst;
  int                          m_owner;
  int                          m_left;
  logic                        m_vld;
  t_ccip_c1_ReqMemHdr          m_hdr;
  logic [CCIP_DATA_WIDTH-1:0]  m_data;
  logic [31:0]                 m_cnt [N];

  function automatic int burst_len(t_ccip_c1_ReqMemHdr h);
    int t;
    t = int'(h.req_type);
    if (t > 2) return 1;
    if (h.cl_len == eCL_LEN_2) return 2;
    if (h.cl_len == eCL_LEN_4) return 4;
    return 1;
  endfunction

  function automatic int exp_ack_idx();
    if (c1TxAlmFull) return -1;
    if (m_burst) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge SoftReset_n) begin
    int idx;
    if (!SoftReset_n) begin
      m_last = N - 1; m_burst = 0; m_owner = 0; m_left = 0;
      m_vld = 1'b0; m_hdr = '0; m_data = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
    end else begin
      idx = exp_ack_idx();
      m_vld = (idx >= 0);
      if (idx >= 0) begin
        m_hdr  = req_hdr[idx];
        m_data = req_data[idx];
        m_cnt[idx] = m_cnt[idx] + 32'd1;
        if (m_burst) begin
          m_left--;
          if (m_left == 0) m_burst = 0;
        end else begin
          m_last = idx;
          if (burst_len(req_hdr[idx]) > 1) begin
            m_burst = 1; m_owner = idx; m_left = burst_len(req_hdr[idx]) - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int e;
    logic [N-1:0] ev;
    if (SoftReset_n) begin
      e = exp_ack_idx();
      ev = '0;
      if (e >= 0) ev[e] = 1'b1;
      chk("req_ack", 640'(req_ack), 640'(ev));
    end
    chk("c1_valid", 640'(c1_valid), 640'(m_vld));
    chk("c1_hdr", 640'(c1_hdr), 640'(m_hdr));
    chk("c1_data", 640'(c1_data), 640'(m_data));
`ifdef ASE_C1TX_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 640'(grant_cnt[i]), 640'(m_cnt[i]));
`endif
    for (int i = 0; i < N; i++) if (req_ack[i]) ack_log.push_back(i);
  end

  function automatic t_ccip_c1_ReqMemHdr mk_hdr(logic [3:0] rt, logic [1:0] len, logic [41:0] addr);
    t_ccip_c1_ReqMemHdr h;
    h = '0;
    h.req_type = t_ccip_c1_req'(rt);
    h.cl_len   = t_ccip_clLen'(len);
    h.sop      = 1'b1;
    h.address  = addr;
    h.mdata    = addr[15:0];
    return h;
  endfunction

  task automatic set_req(int i, bit v, logic [3:0] rt, logic [1:0] len);
    req_valid[i] = v;
    req_hdr[i]   = mk_hdr(rt, len, 42'(tag));
    req_data[i]  = {16{tag}};
    tag++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack order encoded as decimal digits (index + 1), oldest first.
  function automatic int log_code();
    int c;
    c = 0;
    foreach (ack_log[k]) c = c * 10 + ack_log[k] + 1;
    return c;
  endfunction

  initial begin
    SoftReset_n = 1'b0;
    c1TxAlmFull = 1'b0;
    req_valid   = '0;
    req_hdr     = '0;
    req_data    = '0;
    repeat (3) step();
    chk("rst_c1_valid", 640'(c1_valid), 640'(0));
    chk("rst_c1_data", 640'(c1_data), 640'(0));
    SoftReset_n = 1'b1;
    step();

    // All four valid, single-beat: 0,1,2,3,0
    ack_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    repeat (5) step();
    chk("t1_c1_valid_streaming", 640'(c1_valid), 640'(1));
    req_valid = '0;
    step();
    chk("t1_order", 640'(log_code()), 640'(12341));

    // #4CL from requester 2 stays atomic, then 3, then 0
    ack_log.delete();
    set_req(1, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    step();
    set_req(0, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(1, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(2, 1'b1, eREQ_WRLINE_I, eCL_LEN_4);
    set_req(3, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    repeat (6) step();
    req_valid = '0;
    step();
    chk("t2_burst_order", 640'(log_code()), 640'(2333341));

    // Almost-full after beat 2 of a #4CL from requester 1
    ack_log.delete();
    set_req(0, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(1, 1'b1, eREQ_WRLINE_I, eCL_LEN_4);
    repeat (2) step();
    c1TxAlmFull = 1'b1;
    repeat (3) step();
    chk("t3_stalled_log", 640'(log_code()), 640'(22));
    c1TxAlmFull = 1'b0;
    repeat (3) step();
    req_valid = '0;
    step();
    chk("t3_almfull_order", 640'(log_code()), 640'(22221));

    // WrFence #4 and an unrecognised type are single-beat
    ack_log.delete();
    set_req(3, 1'b1, eREQ_WRFENCE, eCL_LEN_4);
    step();
    req_valid = '0;
    set_req(0, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    step();
    req_valid = '0;
    set_req(1, 1'b1, 4'h5, eCL_LEN_4);
    set_req(2, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    repeat (2) step();
    req_valid = '0;
    step();
    chk("t4_single_beat", 640'(log_code()), 640'(4123));

    // Reset in the middle of a #2CL burst from requester 3
    ack_log.delete();
    set_req(0, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(3, 1'b1, eREQ_WRLINE_M, eCL_LEN_2);
    step();
    chk("t5_beat1_out", 640'(c1_valid), 640'(1));
    chk("t5_beat1_owner", 640'(log_code()), 640'(4));
    #2 SoftReset_n = 1'b0;
    #1 chk("t5_rst_c1_valid", 640'(c1_valid), 640'(0));
    repeat (2) step();
    req_valid = '0;
    set_req(1, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(2, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    set_req(3, 1'b1, eREQ_WRLINE_M, eCL_LEN_2);
    SoftReset_n = 1'b1;
    ack_log.delete();
    step();
    req_valid = '0;
    step();
    chk("t5_after_reset", 640'(log_code()), 640'(2));

`ifdef ASE_C1TX_ARB_STATS_EN
    force dut.grant_cnt_q[0] = 32'hFFFF_FFFF;
    m_cnt[0] = 32'hFFFF_FFFF;
    step();
    release dut.grant_cnt_q[0];
    set_req(0, 1'b1, eREQ_WRLINE_I, eCL_LEN_1);
    step();
    req_valid = '0;
    chk("t6_cnt_wrap", 640'(grant_cnt[0]), 640'(0));
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccip_c1tx_arbiter.md
# ccip_c1tx_arbiter

Round-robin arbiter that shares the single CCI-P C1 Tx (memory write) channel among NUM_REQ AFU-side requesters. It sits between the requester ports and the C1 Tx channel the transaction logger watches. It respects c1TxAlmFull backpressure and keeps multi-cacheline write bursts atomic, so beats from different requesters never interleave.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- clk  in  1  channel clock; all logic on rising edge.
- SoftReset_n  in  1  asynchronous active-low reset.
- c1TxAlmFull  in  1  C1 Tx almost-full from the Rx side.
- req_valid  in  NUM_REQ  requester i has a beat ready; held until acked.
- req_hdr  in  NUM_REQ × t_ccip_c1_ReqMemHdr  per-requester header.
- req_data  in  NUM_REQ × CCIP_DATA_WIDTH  per-requester write data.
- req_ack  out  NUM_REQ  one-hot, combinational; beat of requester i is taken this cycle.
- c1_valid  out  1  registered C1 Tx valid.
- c1_hdr  out  t_ccip_c1_ReqMemHdr  registered header.
- c1_data  out  CCIP_DATA_WIDTH  registered data.
- grant_cnt  out  NUM_REQ × 32  per-requester accepted-beat counters (only with macro, see Configuration).

## Operation
- FSM states: IDLE (no burst open) and BURST (locked to owner, beats_left > 0).
- Issue enable: `en = !c1TxAlmFull`. When en = 0, all req_ack = 0 and nothing is issued.
- IDLE with en = 1 and any req_valid:
  - Winner is the first valid requester scanning from rr_ptr+1 upward, with modulo NUM_REQ wrap.
  - Ack the winner and set rr_ptr = winner.
  - If the winner's req_type is eREQ_WRLINE_I, eREQ_WRLINE_M or eREQ_WRPUSH_I and cl_len is eCL_LEN_2 or eCL_LEN_4: go to BURST, owner = winner, beats_left = 1 or 3.
  - Otherwise stay in IDLE. This covers eCL_LEN_1, eREQ_WRFENCE and eREQ_INTR, which are always single-beat.
- BURST with en = 1 and req_valid[owner]:
  - Ack the owner only and decrement beats_left.
  - At 0, return to IDLE.
  - Other requesters are never acked in BURST.
- BURST with the owner not valid, or en = 0: no ack, the burst stays open, and it resumes when the condition clears.
- The header of burst beats 2..n is forwarded unchanged; the arbiter does not rewrite sop or address.
- Unrecognised req_type is treated as single-beat.
- Output register: on an ack, c1_valid ← 1 and c1_hdr/c1_data ← the acked requester's values; otherwise c1_valid ← 0 and hdr/data are held.
- Reset values:
  - c1_valid = 0, c1_hdr = 0, c1_data = 0.
  - state = IDLE, beats_left = 0, rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - grant_cnt all 0.
- Reset mid-burst aborts the burst; the beats already issued are not retracted.

## Timing
- req_ack is combinational from req_valid, req_hdr, c1TxAlmFull and state, in the same cycle.
- The acked beat appears on c1_valid/hdr/data on the next rising edge: 1-cycle latency.
- Peak throughput is 1 beat/cycle. Back-to-back single-beat grants to different requesters in consecutive cycles are allowed.
- c1TxAlmFull takes effect in the same cycle: a rise at edge t means no ack during cycle t. At most one beat already in the output register is still presented.
- When all NUM_REQ requesters stay valid with single-beat requests, each is granted exactly once per NUM_REQ consecutive grants.

## Configuration
- Macro: ASE_C1TX_ARB_STATS_EN.
- Defined:
  - grant_cnt[i] increments by 1 on each req_ack[i].
  - Each counter wraps from 2^32-1 to 0.
  - Counters reset to 0.
- Undefined: the grant_cnt port and its counters are absent; all other behaviour is identical.

## Structure
- In ase_pkg: the state enum t_c1arb_state {C1ARB_IDLE, C1ARB_BURST} and a function c1arb_beats(req_type, cl_len) returning 1/2/4.
- Sub-module rr_picker: a parameterised NUM_REQ round-robin priority picker taking valid and rr_ptr and returning a one-hot grant plus any.
- Arbiter top: FSM, output register and optional counters.

## Test plan
- Reset, then req_valid = 4'b1111 with all single-beat Wr_I and c1TxAlmFull = 0 → acks in order 0,1,2,3,0; c1_valid high every cycle from the cycle after the first ack.
- Requester 2 issues a #4CL Wr_I while requesters 0 and 1 are valid → four consecutive acks to 2 only, then the next ack goes to 3 if valid, else 0.
- c1TxAlmFull rises after beat 2 of a #4CL burst from requester 1 → no ack while it is high, requester 0 is not granted, and beats 3–4 come from requester 1 after it falls.
- Requester 3 sends WrFence with cl_len = eCL_LEN_4 → exactly one beat is acked and FSM stays IDLE.
- Assert SoftReset_n = 0 mid-#2CL burst → c1_valid = 0 immediately, state = IDLE, and the first grant after reset goes to the lowest valid requester index.
- With ASE_C1TX_ARB_STATS_EN defined, preload grant_cnt[0] = 32'hFFFF_FFFF via force and grant once → grant_cnt[0] = 0.
